// File: rtl/signed_divider_8_by_4.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, then sign fix-up.
// Define SIGNED_DIVIDER_OVF_SAT_EN to saturate the overflow quotient instead of wrapping it.
module signed_divider_8_by_4 #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow,
  output logic [1:0]            state_dbg
);

  // Handshake: start is sampled only in IDLE; done is a one-cycle pulse in
  // which results and flags are valid; busy covers the CALC and FIX cycles.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;     // dividend magnitude, becomes quotient magnitude
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W:0]    acc_q, acc_d;
  logic                  dvd_neg_q, dvd_neg_d;
  logic                  dvs_neg_q, dvs_neg_d;
  logic                  dz_q, dz_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;
  logic                  ovf_q, ovf_d;

  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W:0]    diff;
  logic [DIVISOR_W-1:0]  rem_mag;
  logic                  q_neg;

  assign trial   = {acc_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
  assign diff    = trial - {1'b0, dvs_q};
  assign rem_mag = acc_q[DIVISOR_W-1:0];
  assign q_neg   = dvd_neg_q ^ dvs_neg_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      acc_q     <= '0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      acc_q     <= acc_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      dz_q      <= dz_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    acc_d     = acc_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    dz_d      = dz_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_neg_d = dividend[DIVIDEND_W-1];
          dvs_neg_d = divisor[DIVISOR_W-1];
          // The most-negative value negates to itself, which is still the
          // correct unsigned magnitude.
          dvd_d     = dividend[DIVIDEND_W-1] ? -dividend : dividend;
          dvs_d     = divisor[DIVISOR_W-1] ? -divisor : divisor;
          acc_d     = '0;
          cnt_d     = '0;
          dz_d      = (divisor == '0);
          dbz_d     = 1'b0;
          ovf_d     = 1'b0;
          state_d   = (divisor == '0) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (trial >= {1'b0, dvs_q}) begin
          acc_d = diff;
          dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b1};
        end else begin
          acc_d = trial;
          dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIVIDEND_W - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (dz_q) begin
          quot_d = '0;
          rem_d  = '0;
          dbz_d  = 1'b1;
        end else begin
          quot_d = q_neg ? -dvd_q : dvd_q;
          rem_d  = dvd_neg_q ? -rem_mag : rem_mag;
          // Only a positive result can exceed the signed range (magnitude 2^(W-1)).
          if (!q_neg && dvd_q[DIVIDEND_W-1]) begin
            ovf_d = 1'b1;
`ifdef SIGNED_DIVIDER_OVF_SAT_EN
            quot_d = {1'b0, {(DIVIDEND_W-1){1'b1}}};
`else
            quot_d = {1'b1, {(DIVIDEND_W-1){1'b0}}};
`endif
          end
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign state_dbg   = state_q;

endmodule
